axi_burst_arbiter: RTL and testbench

//  Parametrised AXI3 master front-end: arbitrates NUM_CH cache/uncache request channels onto one AXI port.

---
 rtl/axi_arb_pkg.sv | 32 +++
 rtl/axi_arb_picker.sv | 44 ++++
 rtl/axi_burst_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_axi_burst_arbiter.sv | 413 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the AXI3 burst arbiter: FSM state encoding,
// fixed AXI field values and width helpers.
package axi_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_AR,
      ST_R,
      ST_AW,
      ST_W,
      ST_B
   } arb_state_e;

   localparam logic [1:0] BURST_INCR = 2'b01;
   localparam logic [1:0] RESP_OKAY  = 2'b00;
   localparam int         AXI_LEN_W  = 4;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      for (int i = 0; i < 31; i++) begin
         if ((1 << i) < value) r = i + 1;
      end
      return r;
   endfunction

   // A single-beat-only configuration still needs a one-bit length field.
   function automatic int len_width(input int max_burst);
      return (max_burst > 1) ? clog2(max_burst) : 1;
   endfunction

endpackage

// File: rtl/axi_arb_picker.sv
// Combinational one-hot winner selection over the request vector.
// ARB_ROUND_ROBIN_EN selects rotating priority from ptr; otherwise lowest index wins.
module axi_arb_picker
   import axi_arb_pkg::*;
#(
   parameter int NUM_CH = 4,
   localparam int CH_W  = clog2(NUM_CH)
) (
   input  logic [NUM_CH-1:0] req,
`ifdef ARB_ROUND_ROBIN_EN
   input  logic [CH_W-1:0]   ptr,
`endif
   output logic [NUM_CH-1:0] grant
);

`ifdef ARB_ROUND_ROBIN_EN
   int idx;

   // Walk from the farthest offset back to ptr so the closest requester is written last.
   always_comb begin
      grant = '0;
      idx   = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NUM_CH) idx = idx - NUM_CH;
         if (req[idx]) begin
            grant      = '0;
            grant[idx] = 1'b1;
         end
      end
   end
`else
   always_comb begin
      grant = '0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (req[i]) begin
            grant    = '0;
            grant[i] = 1'b1;
         end
      end
   end
`endif

endmodule

// File: rtl/axi_burst_arbiter.sv
// AXI3 master front-end: arbitrates NUM_CH request channels onto one AXI port,
// one outstanding burst at a time. Define ARB_ROUND_ROBIN_EN for rotating priority.
module axi_burst_arbiter
   import axi_arb_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MAX_BURST = 16,
   localparam int LEN_W    = len_width(MAX_BURST),
   localparam int STRB_W   = DATA_W / 8
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          ch_req,
   input  logic [NUM_CH-1:0]          ch_rw,
   input  logic [NUM_CH*ADDR_W-1:0]   ch_addr,
   input  logic [NUM_CH*LEN_W-1:0]    ch_len,
   input  logic [NUM_CH*DATA_W-1:0]   ch_wdata,
   input  logic [NUM_CH*STRB_W-1:0]   ch_wstrb,
   output logic [NUM_CH-1:0]          ch_grant,
   output logic [NUM_CH-1:0]          ch_wbeat,
   output logic [NUM_CH-1:0]          ch_rvalid,
   output logic [DATA_W-1:0]          ch_rdata,
   output logic [NUM_CH-1:0]          ch_done,
   output logic                       ch_err,
   output logic [3:0]                 arid,
   output logic [ADDR_W-1:0]          araddr,
   output logic [AXI_LEN_W-1:0]       arlen,
   output logic [2:0]                 arsize,
   output logic [1:0]                 arburst,
   output logic [1:0]                 arlock,
   output logic [3:0]                 arcache,
   output logic [2:0]                 arprot,
   output logic                       arvalid,
   input  logic                       arready,
   input  logic                       rvalid,
   input  logic [DATA_W-1:0]          rdata,
   input  logic [1:0]                 rresp,
   input  logic                       rlast,
   output logic                       rready,
   output logic [3:0]                 awid,
   output logic [ADDR_W-1:0]          awaddr,
   output logic [AXI_LEN_W-1:0]       awlen,
   output logic [2:0]                 awsize,
   output logic [1:0]                 awburst,
   output logic [1:0]                 awlock,
   output logic [3:0]                 awcache,
   output logic [2:0]                 awprot,
   output logic                       awvalid,
   input  logic                       awready,
   output logic [3:0]                 wid,
   output logic [DATA_W-1:0]          wdata,
   output logic [STRB_W-1:0]          wstrb,
   output logic                       wlast,
   output logic                       wvalid,
   input  logic                       wready,
   input  logic                       bvalid,
   input  logic [1:0]                 bresp,
   output logic                       bready
);

   localparam int         CH_W     = clog2(NUM_CH);
   localparam logic [2:0] AXI_SIZE = 3'(clog2(STRB_W));

   arb_state_e          state_q, state_d;
   logic [CH_W-1:0]     g_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    cnt_q;
   logic                err_q;
   logic [NUM_CH-1:0]   win_oh;
   logic [CH_W-1:0]     win_idx;
   logic [NUM_CH-1:0]   g_sel;
   logic                at_last;

`ifdef ARB_ROUND_ROBIN_EN
   logic [CH_W-1:0]     ptr_q;

   always_ff @(posedge clk) begin
      if (!reset) begin
         ptr_q <= '0;
      end else if (|ch_done) begin
         ptr_q <= (g_q == CH_W'(NUM_CH - 1)) ? '0 : g_q + CH_W'(1);
      end
   end
`endif

   axi_arb_picker #(
      .NUM_CH (NUM_CH)
   ) u_picker (
      .req   (ch_req),
`ifdef ARB_ROUND_ROBIN_EN
      .ptr   (ptr_q),
`endif
      .grant (win_oh)
   );

   always_comb begin
      win_idx = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (win_oh[i]) win_idx = CH_W'(i);
      end
   end

   assign g_sel   = NUM_CH'(1) << g_q;
   assign at_last = (cnt_q == len_q);

   // Fixed AXI attributes and the latched request fields.
   assign arid    = '0;
   assign araddr  = addr_q;
   assign arlen   = AXI_LEN_W'(len_q);
   assign arsize  = AXI_SIZE;
   assign arburst = BURST_INCR;
   assign arlock  = '0;
   assign arcache = '0;
   assign arprot  = '0;
   assign awid    = '0;
   assign awaddr  = addr_q;
   assign awlen   = AXI_LEN_W'(len_q);
   assign awsize  = AXI_SIZE;
   assign awburst = BURST_INCR;
   assign awlock  = '0;
   assign awcache = '0;
   assign awprot  = '0;
   assign wid     = '0;
   assign wdata   = ch_wdata[g_q*DATA_W +: DATA_W];
   assign wstrb   = ch_wstrb[g_q*STRB_W +: STRB_W];

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_IDLE;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               cnt_q <= '0;
               err_q <= 1'b0;
            end
            // The counter parks at len so an overlong burst drains without wrapping.
            ST_R: begin
               if (rvalid) begin
                  if (!at_last) cnt_q <= cnt_q + LEN_W'(1);
                  if (rresp != RESP_OKAY) err_q <= 1'b1;
               end
            end
            ST_W: begin
               if (wready && !at_last) cnt_q <= cnt_q + LEN_W'(1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state_q == ST_IDLE && (|ch_req)) begin
         g_q    <= win_idx;
         addr_q <= ch_addr[win_idx*ADDR_W +: ADDR_W];
         len_q  <= ch_len[win_idx*LEN_W +: LEN_W];
      end
   end

   always_comb begin
      state_d   = state_q;
      arvalid   = 1'b0;
      awvalid   = 1'b0;
      rready    = 1'b0;
      wvalid    = 1'b0;
      wlast     = 1'b0;
      bready    = 1'b0;
      ch_grant  = '0;
      ch_wbeat  = '0;
      ch_rvalid = '0;
      ch_done   = '0;
      ch_err    = 1'b0;
      ch_rdata  = '0;
      case (state_q)
         ST_IDLE: begin
            if (|ch_req) state_d = ch_rw[win_idx] ? ST_AW : ST_AR;
         end
         ST_AR: begin
            arvalid = 1'b1;
            if (arready) begin
               ch_grant = g_sel;
               state_d  = ST_R;
            end
         end
         ST_R: begin
            rready = 1'b1;
            if (rvalid) begin
               ch_rvalid = g_sel;
               ch_rdata  = rdata;
               if (rlast) begin
                  ch_done = g_sel;
                  ch_err  = err_q | (rresp != RESP_OKAY) | !at_last;
                  state_d = ST_IDLE;
               end
            end
         end
         ST_AW: begin
            awvalid = 1'b1;
            if (awready) begin
               ch_grant = g_sel;
               state_d  = ST_W;
            end
         end
         ST_W: begin
            wvalid = 1'b1;
            wlast  = at_last;
            if (wready) begin
               ch_wbeat = g_sel;
               if (at_last) state_d = ST_B;
            end
         end
         ST_B: begin
            bready = 1'b1;
            if (bvalid) begin
               ch_done = g_sel;
               ch_err  = (bresp != RESP_OKAY);
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_axi_burst_arbiter.sv
// Scoreboard bench for axi_burst_arbiter: the bench plays the AXI slave and the
// requesting channels; expected beats are queued when driven and popped on output.
module tb_axi_burst_arbiter;

   localparam int NUM_CH = 4;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int LEN_W  = 4;
   localparam int STRB_W = 4;

   logic                      clk;
   logic                      reset;
   logic [NUM_CH-1:0]         ch_req;
   logic [NUM_CH-1:0]         ch_rw;
   logic [NUM_CH*ADDR_W-1:0]  ch_addr;
   logic [NUM_CH*LEN_W-1:0]   ch_len;
   logic [NUM_CH*DATA_W-1:0]  ch_wdata;
   logic [NUM_CH*STRB_W-1:0]  ch_wstrb;
   logic [NUM_CH-1:0]         ch_grant, ch_wbeat, ch_rvalid, ch_done;
   logic [DATA_W-1:0]         ch_rdata;
   logic                      ch_err;
   logic [3:0]                arid, awid, wid;
   logic [ADDR_W-1:0]         araddr, awaddr;
   logic [3:0]                arlen, awlen;
   logic [2:0]                arsize, awsize, arprot, awprot;
   logic [1:0]                arburst, awburst, arlock, awlock;
   logic [3:0]                arcache, awcache;
   logic                      arvalid, arready, rvalid, rlast, rready;
   logic [DATA_W-1:0]         rdata, wdata;
   logic [1:0]                rresp, bresp;
   logic                      awvalid, awready, wlast, wvalid, wready, bvalid, bready;
   logic [STRB_W-1:0]         wstrb;

   int n_checks = 0;
   int n_errors = 0;
   int rr_ptr   = 0;
   logic [DATA_W-1:0] rq[$];
   logic [DATA_W-1:0] wq[$];

   axi_burst_arbiter #(
      .NUM_CH(NUM_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(16)
   ) dut (
      .clk(clk), .reset(reset),
      .ch_req(ch_req), .ch_rw(ch_rw), .ch_addr(ch_addr), .ch_len(ch_len),
      .ch_wdata(ch_wdata), .ch_wstrb(ch_wstrb),
      .ch_grant(ch_grant), .ch_wbeat(ch_wbeat), .ch_rvalid(ch_rvalid),
      .ch_rdata(ch_rdata), .ch_done(ch_done), .ch_err(ch_err),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
      .rvalid(rvalid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rready(rready),
      .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
      .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
      .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
      .bvalid(bvalid), .bresp(bresp), .bready(bready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1);
   end

   function automatic logic [NUM_CH-1:0] oh(input int c);
      logic [NUM_CH-1:0] v;
      v = '0;
      v[c] = 1'b1;
      return v;
   endfunction

   function automatic int rr_pick(input logic [NUM_CH-1:0] req);
`ifdef ARB_ROUND_ROBIN_EN
      for (int i = 0; i < NUM_CH; i++) begin
         if (req[(rr_ptr + i) % NUM_CH]) return (rr_ptr + i) % NUM_CH;
      end
      return 0;
`else
      for (int i = 0; i < NUM_CH; i++) begin
         if (req[i]) return i;
      end
      return 0;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_read(input int ch, input logic [31:0] addr, input int len,
                           input int ar_wait, input int bad_beat, input int last_beat,
                           input bit gap, input bit exp_err);
      logic [DATA_W-1:0] d;
      ch_req[ch] = 1'b1;
      ch_rw[ch]  = 1'b0;
      ch_addr[ch*ADDR_W +: ADDR_W] = addr;
      ch_len[ch*LEN_W +: LEN_W]    = LEN_W'(len);
      tick();
      for (int w = 0; w <= ar_wait; w++) begin
         arready = (w == ar_wait);
         @(negedge clk);
         n_checks++;
         if (arvalid !== 1'b1 || araddr !== addr || arlen !== 4'(len) || arburst !== 2'b01 || arsize !== 3'd2) begin
            n_errors++;
            $display("FAIL ar_channel ch%0d: arvalid=%b araddr=%h arlen=%0d, required 1 %h %0d", ch, arvalid, araddr, arlen, addr, len);
         end
         n_checks++;
         if (ch_grant !== (arready ? oh(ch) : 4'b0000)) begin
            n_errors++;
            $display("FAIL ar_grant ch%0d wait%0d: got %b required %b", ch, w, ch_grant, arready ? oh(ch) : 4'b0000);
         end
         tick();
      end
      arready = 1'b0;
      ch_req[ch] = 1'b0;
      for (int b = 0; b <= last_beat; b++) begin
         if (gap && b == 3) begin
            rvalid = 1'b0;
            @(negedge clk);
            n_checks++;
            if (ch_rvalid !== 4'b0000 || rready !== 1'b1) begin
               n_errors++;
               $display("FAIL read_gap ch%0d: ch_rvalid=%b rready=%b required 0000 1", ch, ch_rvalid, rready);
            end
            tick();
         end
         d      = $urandom;
         rvalid = 1'b1;
         rdata  = d;
         rresp  = (b == bad_beat) ? 2'b10 : 2'b00;
         rlast  = (b == last_beat);
         rq.push_back(d);
         @(negedge clk);
         n_checks++;
         if (ch_rvalid !== oh(ch) || ch_rdata !== rq.pop_front()) begin
            n_errors++;
            $display("FAIL read_beat ch%0d beat%0d: ch_rvalid=%b ch_rdata=%h required %b %h", ch, b, ch_rvalid, ch_rdata, oh(ch), d);
         end
         n_checks++;
         if (ch_done !== ((b == last_beat) ? oh(ch) : 4'b0000)) begin
            n_errors++;
            $display("FAIL read_done ch%0d beat%0d: got %b", ch, b, ch_done);
         end
         if (b == last_beat) begin
            n_checks++;
            if (ch_err !== exp_err) begin
               n_errors++;
               $display("FAIL read_err ch%0d: got %b required %b", ch, ch_err, exp_err);
            end
            rr_ptr = (ch + 1) % NUM_CH;
         end
         tick();
      end
      rvalid = 1'b0;
      rlast  = 1'b0;
      rresp  = 2'b00;
      @(negedge clk);
      n_checks++;
      if (rready !== 1'b0 || arvalid !== 1'b0 || ch_rdata !== '0) begin
         n_errors++;
         $display("FAIL read_idle ch%0d: rready=%b arvalid=%b ch_rdata=%h required 0 0 0", ch, rready, arvalid, ch_rdata);
      end
   endtask

   task automatic run_write(input int ch, input logic [31:0] addr, input int len,
                            input logic [3:0] strb, input bit toggle,
                            input logic [1:0] resp, input bit exp_err);
      int beats, cyc, wbeat_cnt, wlast_cnt;
      logic [DATA_W-1:0] d;
      beats = 0; cyc = 0; wbeat_cnt = 0; wlast_cnt = 0;
      ch_req[ch] = 1'b1;
      ch_rw[ch]  = 1'b1;
      ch_addr[ch*ADDR_W +: ADDR_W]  = addr;
      ch_len[ch*LEN_W +: LEN_W]     = LEN_W'(len);
      ch_wstrb[ch*STRB_W +: STRB_W] = strb;
      d = {8'(ch), 8'hA5, 16'(0)};
      ch_wdata[ch*DATA_W +: DATA_W] = d;
      wq.push_back(d);
      tick();
      awready = 1'b1;
      @(negedge clk);
      n_checks++;
      if (awvalid !== 1'b1 || awaddr !== addr || awlen !== 4'(len) || ch_grant !== oh(ch)) begin
         n_errors++;
         $display("FAIL aw_channel ch%0d: awvalid=%b awaddr=%h awlen=%0d grant=%b required 1 %h %0d %b", ch, awvalid, awaddr, awlen, ch_grant, addr, len, oh(ch));
      end
      tick();
      awready = 1'b0;
      ch_req[ch] = 1'b0;
      while (beats <= len && cyc < 100) begin
         wready = toggle ? cyc[0] : 1'b1;
         @(negedge clk);
         n_checks++;
         if (wvalid !== 1'b1 || wlast !== (beats == len) || wstrb !== strb || wdata !== wq[0]) begin
            n_errors++;
            $display("FAIL w_beat ch%0d beat%0d: wvalid=%b wlast=%b wstrb=%b wdata=%h required 1 %b %b %h", ch, beats, wvalid, wlast, wstrb, wdata, beats == len, strb, wq[0]);
         end
         n_checks++;
         if (ch_wbeat !== (wready ? oh(ch) : 4'b0000)) begin
            n_errors++;
            $display("FAIL w_consume ch%0d cyc%0d: ch_wbeat=%b wready=%b", ch, cyc, ch_wbeat, wready);
         end
         if (ch_wbeat[ch]) wbeat_cnt++;
         if (wlast && wready) wlast_cnt++;
         if (wready) begin
            void'(wq.pop_front());
            beats++;
            tick();
            if (beats <= len) begin
               d = {8'(ch), 8'hA5, 16'(beats)};
               ch_wdata[ch*DATA_W +: DATA_W] = d;
               wq.push_back(d);
            end
         end else begin
            tick();
         end
         cyc++;
      end
      wready = 1'b0;
      n_checks++;
      if (wbeat_cnt != len + 1 || wlast_cnt != 1) begin
         n_errors++;
         $display("FAIL w_count ch%0d: wbeat pulses=%0d wlast beats=%0d required %0d 1", ch, wbeat_cnt, wlast_cnt, len + 1);
      end
      @(negedge clk);
      n_checks++;
      if (bready !== 1'b1 || wvalid !== 1'b0 || ch_done !== 4'b0000) begin
         n_errors++;
         $display("FAIL b_wait ch%0d: bready=%b wvalid=%b done=%b required 1 0 0000", ch, bready, wvalid, ch_done);
      end
      tick();
      bvalid = 1'b1;
      bresp  = resp;
      @(negedge clk);
      n_checks++;
      if (ch_done !== oh(ch) || ch_err !== exp_err) begin
         n_errors++;
         $display("FAIL b_done ch%0d: done=%b err=%b required %b %b", ch, ch_done, ch_err, oh(ch), exp_err);
      end
      rr_ptr = (ch + 1) % NUM_CH;
      tick();
      bvalid = 1'b0;
      bresp  = 2'b00;
      @(negedge clk);
      n_checks++;
      if (bready !== 1'b0 || awvalid !== 1'b0) begin
         n_errors++;
         $display("FAIL b_idle ch%0d: bready=%b awvalid=%b required 0 0", ch, bready, awvalid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b0;
      tick();
      tick();
      @(negedge clk);
      n_checks++;
      if ({arvalid, awvalid, wvalid, rready, bready} !== 5'b0) begin
         n_errors++;
         $display("FAIL reset_axi: ar/aw/w valid, r/b ready = %b required 00000", {arvalid, awvalid, wvalid, rready, bready});
      end
      n_checks++;
      if ({ch_grant, ch_wbeat, ch_rvalid, ch_done, ch_err} !== 17'b0 || ch_rdata !== '0) begin
         n_errors++;
         $display("FAIL reset_ch: grant=%b wbeat=%b rvalid=%b done=%b err=%b rdata=%h required all 0", ch_grant, ch_wbeat, ch_rvalid, ch_done, ch_err, ch_rdata);
      end
      reset  = 1'b1;
      rr_ptr = 0;
      tick();
   endtask

   task automatic test_read_burst();
      run_read(2, 32'h0000_1000, 15, 2, -1, 15, 1'b1, 1'b0);
   endtask

   task automatic test_write_single();
      run_write(1, 32'h0000_2040, 0, 4'b0011, 1'b0, 2'b00, 1'b0);
   endtask

   task automatic test_arbitration();
      int w;
      reset = 1'b0;
      tick();
      reset  = 1'b1;
      rr_ptr = 0;
      ch_rw[0] = 1'b0;
      ch_rw[3] = 1'b0;
      ch_addr[0*ADDR_W +: ADDR_W] = 32'h0000_0100;
      ch_addr[3*ADDR_W +: ADDR_W] = 32'h0000_0300;
      ch_len[0*LEN_W +: LEN_W] = '0;
      ch_len[3*LEN_W +: LEN_W] = '0;
      ch_req[0] = 1'b1;
      ch_req[3] = 1'b1;
      for (int t = 0; t < 3; t++) begin
         w = rr_pick(4'b1001);
         tick();
         arready = 1'b1;
         @(negedge clk);
         n_checks++;
         if (ch_grant !== oh(w) || araddr !== ((w == 0) ? 32'h0000_0100 : 32'h0000_0300)) begin
            n_errors++;
            $display("FAIL arb_grant round%0d: grant=%b araddr=%h required %b (ch%0d)", t, ch_grant, araddr, oh(w), w);
         end
         tick();
         arready = 1'b0;
         rvalid  = 1'b1;
         rlast   = 1'b1;
         rdata   = $urandom;
         rq.push_back(rdata);
         @(negedge clk);
         n_checks++;
         if (ch_done !== oh(w) || ch_rvalid !== oh(w) || ch_rdata !== rq.pop_front() || ch_err !== 1'b0) begin
            n_errors++;
            $display("FAIL arb_done round%0d: done=%b rvalid=%b err=%b required %b", t, ch_done, ch_rvalid, ch_err, oh(w));
         end
         rr_ptr = (w + 1) % NUM_CH;
         tick();
         rvalid = 1'b0;
         rlast  = 1'b0;
         @(negedge clk);
         n_checks++;
         if (arvalid !== 1'b0 || ch_grant !== 4'b0000) begin
            n_errors++;
            $display("FAIL arb_idle_gap round%0d: arvalid=%b grant=%b required 0 0000", t, arvalid, ch_grant);
         end
      end
      ch_req[0] = 1'b0;
      ch_req[3] = 1'b0;
      tick();
   endtask

   task automatic test_read_errors();
      run_read(1, 32'h0000_2000, 3, 0, 2, 3, 1'b0, 1'b1);
      run_read(2, 32'h0000_2400, 3, 1, -1, 1, 1'b0, 1'b1);
      run_read(0, 32'h0000_2800, 3, 0, -1, 3, 1'b0, 1'b0);
   endtask

   task automatic test_write_slverr();
      run_write(3, 32'h0000_5000, 2, 4'b1111, 1'b0, 2'b10, 1'b1);
   endtask

   task automatic test_reset_mid_burst();
      ch_req[0] = 1'b1;
      ch_rw[0]  = 1'b1;
      ch_addr[0*ADDR_W +: ADDR_W]  = 32'h0000_4000;
      ch_len[0*LEN_W +: LEN_W]     = 4'd15;
      ch_wstrb[0*STRB_W +: STRB_W] = 4'hF;
      tick();
      awready = 1'b1;
      tick();
      awready   = 1'b0;
      ch_req[0] = 1'b0;
      wready    = 1'b1;
      for (int b = 0; b < 4; b++) begin
         @(negedge clk);
         n_checks++;
         if (ch_wbeat !== 4'b0001 || wlast !== 1'b0) begin
            n_errors++;
            $display("FAIL rst_burst_beat%0d: ch_wbeat=%b wlast=%b required 0001 0", b, ch_wbeat, wlast);
         end
         tick();
      end
      reset = 1'b0;
      tick();
      @(negedge clk);
      n_checks++;
      if ({wvalid, awvalid, arvalid, bready, rready} !== 5'b0 || ch_wbeat !== 4'b0000) begin
         n_errors++;
         $display("FAIL rst_abandon: w/aw/ar valid b/r ready=%b ch_wbeat=%b required 00000 0000", {wvalid, awvalid, arvalid, bready, rready}, ch_wbeat);
      end
      reset  = 1'b1;
      wready = 1'b0;
      rr_ptr = 0;
      tick();
      run_read(3, 32'h0000_3000, 1, 0, -1, 1, 1'b0, 1'b0);
   endtask

   task automatic test_wready_toggle();
      run_write(2, 32'h0000_6000, 15, 4'b1111, 1'b1, 2'b00, 1'b0);
   endtask

   initial begin
      reset    = 1'b0;
      ch_req   = '0;
      ch_rw    = '0;
      ch_addr  = '0;
      ch_len   = '0;
      ch_wdata = '0;
      ch_wstrb = '0;
      arready  = 1'b0;
      rvalid   = 1'b0;
      rdata    = '0;
      rresp    = 2'b00;
      rlast    = 1'b0;
      awready  = 1'b0;
      wready   = 1'b0;
      bvalid   = 1'b0;
      bresp    = 2'b00;
      test_reset();
      test_read_burst();
      test_write_single();
      test_arbitration();
      test_read_errors();
      test_write_slverr();
      test_reset_mid_burst();
      test_wready_toggle();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
